// File: rtl/wptr_full_level.sv
// Write-side pointer/status block for an asynchronous FIFO: binary and Gray write
// pointers, RAM write address, full, almost-full, fill level, sticky overflow and write ack.
module wptr_full_level #(
  parameter int ADDRSIZE = 4
) (
  input  logic                i_wclk,
  input  logic                i_wrst_n,
  input  logic                i_w_en,
  input  logic [ADDRSIZE:0]   i_rptr_sync,
  input  logic [ADDRSIZE:0]   i_afull_thresh,
  input  logic                i_clr_ovf,
  output logic [ADDRSIZE-1:0] o_waddr,
  output logic [ADDRSIZE:0]   o_wptr,
  output logic                o_wfull_flag,
  output logic                o_wafull_flag,
  output logic [ADDRSIZE:0]   o_wlevel,
  output logic                o_wovf,
  output logic                o_wack
);

  logic [ADDRSIZE:0] wbin_q, wbin_d;
  logic [ADDRSIZE:0] wgray_q, wgray_d;
  logic [ADDRSIZE:0] level_q, level_d;
  logic [ADDRSIZE:0] rbin_sync;
  logic [ADDRSIZE:0] rgray_full;
  logic              full_q, full_d;
  logic              afull_q, afull_d;
  logic              ovf_q, ovf_d;
  logic              wack_q, wack_d;
  logic              accept;
  logic              ovf_attempt;

  assign accept      = i_w_en & ~full_q;
  assign ovf_attempt = i_w_en & full_q;

  // Full when the write pointer is one lap ahead: top two Gray bits inverted, rest equal.
  assign rgray_full = {~i_rptr_sync[ADDRSIZE:ADDRSIZE-1], i_rptr_sync[ADDRSIZE-2:0]};

  always_comb begin
    rbin_sync = '0;
    for (int k = 0; k <= ADDRSIZE; k++) begin
      rbin_sync[k] = ^(i_rptr_sync >> k);
    end
  end

  always_comb begin
    wbin_d  = wbin_q + {{ADDRSIZE{1'b0}}, accept};
    wgray_d = (wbin_d >> 1) ^ wbin_d;
    full_d  = (wgray_d == rgray_full);
    // Synchronised read pointer lags, so this level only ever over-reports.
    level_d = wbin_d - rbin_sync;
    afull_d = (level_d >= i_afull_thresh);
    wack_d  = accept;
    ovf_d   = ovf_q;
    if (ovf_attempt) begin
      ovf_d = 1'b1;
    end else if (i_clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge i_wclk or negedge i_wrst_n) begin
    if (!i_wrst_n) begin
      wbin_q  <= '0;
      wgray_q <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
      afull_q <= 1'b0;
      ovf_q   <= 1'b0;
      wack_q  <= 1'b0;
    end else begin
      wbin_q  <= wbin_d;
      wgray_q <= wgray_d;
      level_q <= level_d;
      full_q  <= full_d;
      afull_q <= afull_d;
      ovf_q   <= ovf_d;
      wack_q  <= wack_d;
    end
  end

  assign o_waddr       = wbin_q[ADDRSIZE-1:0];
  assign o_wptr        = wgray_q;
  assign o_wfull_flag  = full_q;
  assign o_wafull_flag = afull_q;
  assign o_wlevel      = level_q;
  assign o_wovf        = ovf_q;
  assign o_wack        = wack_q;

endmodule

// File: tb/tb_wptr_full_level.sv
// Directed bench for wptr_full_level (ADDRSIZE=4) with a reference model feeding
// a scoreboard queue of expected registered outputs.
module tb_wptr_full_level;

  localparam int AW = 4;

  logic          clk;
  logic          rstN;
  logic          wEn;
  logic [AW:0]   rptrSync;
  logic [AW:0]   afullThresh;
  logic          clrOvf;
  logic [AW-1:0] waddr;
  logic [AW:0]   wptr;
  logic          wfull;
  logic          wafull;
  logic [AW:0]   wlevel;
  logic          wovf;
  logic          wack;

  typedef struct {
    logic [AW-1:0] waddr;
    logic [AW:0]   wptr;
    logic          full;
    logic          afull;
    logic [AW:0]   level;
    logic          ovf;
    logic          ack;
  } exp_t;

  exp_t sb[$];

  int testCount = 0;
  int failCount = 0;
  int ackCount  = 0;

  logic [AW:0] mWbin;
  logic        mFull;
  logic        mOvf;

  wptr_full_level #(.ADDRSIZE(AW)) dut (
    .i_wclk         (clk),
    .i_wrst_n       (rstN),
    .i_w_en         (wEn),
    .i_rptr_sync    (rptrSync),
    .i_afull_thresh (afullThresh),
    .i_clr_ovf      (clrOvf),
    .o_waddr        (waddr),
    .o_wptr         (wptr),
    .o_wfull_flag   (wfull),
    .o_wafull_flag  (wafull),
    .o_wlevel       (wlevel),
    .o_wovf         (wovf),
    .o_wack         (wack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkField(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sb.size() == 0) begin
      checkField("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    checkField("waddr", {28'd0, waddr}, {28'd0, e.waddr});
    checkField("wptr", {27'd0, wptr}, {27'd0, e.wptr});
    checkField("full", {31'd0, wfull}, {31'd0, e.full});
    checkField("afull", {31'd0, wafull}, {31'd0, e.afull});
    checkField("level", {27'd0, wlevel}, {27'd0, e.level});
    checkField("ovf", {31'd0, wovf}, {31'd0, e.ovf});
    checkField("ack", {31'd0, wack}, {31'd0, e.ack});
    if (wack === 1'b1) ackCount++;
  endtask

  task automatic checkAllZero(input string tag);
    checkField({tag, "_waddr"}, {28'd0, waddr}, 32'd0);
    checkField({tag, "_wptr"}, {27'd0, wptr}, 32'd0);
    checkField({tag, "_full"}, {31'd0, wfull}, 32'd0);
    checkField({tag, "_afull"}, {31'd0, wafull}, 32'd0);
    checkField({tag, "_level"}, {27'd0, wlevel}, 32'd0);
    checkField({tag, "_ovf"}, {31'd0, wovf}, 32'd0);
    checkField({tag, "_ack"}, {31'd0, wack}, 32'd0);
  endtask

  // rbin is the binary read position; the bench converts it to Gray for the DUT.
  task automatic applyStimulus(input logic wen, input logic [AW:0] rbin,
                               input logic [AW:0] thresh, input logic clr);
    exp_t        e;
    logic        acc;
    logic [AW:0] lvl;
    wEn         = wen;
    rptrSync    = rbin ^ (rbin >> 1);
    afullThresh = thresh;
    clrOvf      = clr;
    if (!rstN) begin
      mWbin = '0;
      mFull = 1'b0;
      mOvf  = 1'b0;
      e = '{default: '0};
    end else begin
      acc = wen & ~mFull;
      if (wen & mFull) mOvf = 1'b1;
      else if (clr) mOvf = 1'b0;
      mWbin   = mWbin + {{AW{1'b0}}, acc};
      lvl     = mWbin - rbin;
      mFull   = (lvl == 5'd16);
      e.waddr = mWbin[AW-1:0];
      e.wptr  = mWbin ^ (mWbin >> 1);
      e.full  = mFull;
      e.afull = (lvl >= thresh);
      e.level = lvl;
      e.ovf   = mOvf;
      e.ack   = acc;
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    rstN        = 1'b0;
    wEn         = 1'b0;
    rptrSync    = '0;
    afullThresh = 5'd12;
    clrOvf      = 1'b0;
    mWbin       = '0;
    mFull       = 1'b0;
    mOvf        = 1'b0;

    // Reset held: writes requested but nothing moves.
    applyStimulus(1'b1, 5'd0, 5'd12, 1'b0);
    applyStimulus(1'b1, 5'd0, 5'd12, 1'b0);
    checkAllZero("reset_init");
    rstN = 1'b1;

    // Five writes, then an asynchronous reset between edges.
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 5'd0, 5'd12, 1'b0);
    checkField("five_writes_level", {27'd0, wlevel}, 32'd5);
    #2 rstN = 1'b0;
    #1 checkAllZero("async_reset");
    applyStimulus(1'b1, 5'd0, 5'd12, 1'b0);
    rstN = 1'b1;
    applyStimulus(1'b0, 5'd0, 5'd12, 1'b0);
    checkAllZero("post_reset_idle");

    // Fill to full with almost-full at 12.
    ackCount = 0;
    for (int i = 1; i <= 16; i++) begin
      applyStimulus(1'b1, 5'd0, 5'd12, 1'b0);
      if (i == 11) checkField("afull_before_12", {31'd0, wafull}, 32'd0);
      if (i == 12) begin
        checkField("afull_at_12", {31'd0, wafull}, 32'd1);
        checkField("level_at_12", {27'd0, wlevel}, 32'd12);
      end
    end
    checkField("full_at_16", {31'd0, wfull}, 32'd1);
    checkField("level_at_16", {27'd0, wlevel}, 32'd16);
    checkField("wptr_at_16", {27'd0, wptr}, 32'b11000);
    checkField("waddr_at_16", {28'd0, waddr}, 32'd0);

    // 17th request blocked, overflow set.
    applyStimulus(1'b1, 5'd0, 5'd12, 1'b0);
    checkField("ovf_17th", {31'd0, wovf}, 32'd1);
    checkField("wptr_17th", {27'd0, wptr}, 32'b11000);
    checkField("ack_count_16", ackCount, 32'd16);

    // Attempt and clear together: set wins; then clear alone.
    applyStimulus(1'b1, 5'd0, 5'd12, 1'b1);
    checkField("ovf_set_wins", {31'd0, wovf}, 32'd1);
    applyStimulus(1'b0, 5'd0, 5'd12, 1'b1);
    checkField("ovf_cleared", {31'd0, wovf}, 32'd0);

    // Drain: read pointer steps to Gray 1 then Gray 3.
    applyStimulus(1'b0, 5'd1, 5'd12, 1'b0);
    checkField("drain_full_low", {31'd0, wfull}, 32'd0);
    checkField("drain_level_15", {27'd0, wlevel}, 32'd15);
    applyStimulus(1'b0, 5'd2, 5'd12, 1'b0);
    checkField("drain_level_14", {27'd0, wlevel}, 32'd14);
    applyStimulus(1'b1, 5'd2, 5'd12, 1'b0);
    applyStimulus(1'b1, 5'd2, 5'd12, 1'b0);
    checkField("refull", {31'd0, wfull}, 32'd1);
    // Write held while read advances under full: blocked now, accepted next cycle.
    applyStimulus(1'b1, 5'd3, 5'd12, 1'b0);
    checkField("held_blocked_ack", {31'd0, wack}, 32'd0);
    checkField("held_release_full", {31'd0, wfull}, 32'd0);
    applyStimulus(1'b1, 5'd3, 5'd12, 1'b0);
    checkField("held_accepted_ack", {31'd0, wack}, 32'd1);
    checkField("held_accepted_level", {27'd0, wlevel}, 32'd16);
    applyStimulus(1'b0, 5'd3, 5'd12, 1'b1);

    // Wrap-around with the reader 4 behind, threshold beyond depth.
    rstN = 1'b0;
    applyStimulus(1'b0, 5'd0, 5'd17, 1'b0);
    rstN = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (i < 4) applyStimulus(1'b1, 5'd0, 5'd17, 1'b0);
      else applyStimulus(1'b1, mWbin - 5'd3, 5'd17, 1'b0);
      if (i >= 4) checkField("wrap_level_4", {27'd0, wlevel}, 32'd4);
      if (i == 30) checkField("wrap_wptr_31", {27'd0, wptr}, 32'b10000);
      if (i == 31) checkField("wrap_wptr_0", {27'd0, wptr}, 32'd0);
      checkField("wrap_no_full", {31'd0, wfull}, 32'd0);
      checkField("wrap_no_afull", {31'd0, wafull}, 32'd0);
    end

    // Threshold zero forces almost-full.
    applyStimulus(1'b0, mWbin - 5'd4, 5'd0, 1'b0);
    checkField("thresh_zero_afull", {31'd0, wafull}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/wptr_full_level.md
# wptr_full_level

Write-side pointer and status block for the asynchronous FIFO, successor to the basic write-pointer/full generator. It keeps the binary and Gray write pointers, produces the RAM write address, and raises the full flag. It adds:

- a write-domain fill level,
- a programmable almost-full flag,
- a sticky overflow flag with clear,
- a registered write-accept strobe.

It sits in the write clock domain, between the write client and the RAM. It takes the read pointer only after that pointer has been through the 2-flop synchroniser.

## Interface

Parameters:
- ADDRSIZE, default 4: RAM address width. FIFO depth is 2^ADDRSIZE. Legal range is ADDRSIZE >= 2.

Ports (one clock; reset is asynchronous and active-low):
- i_wclk  input  1  write-domain clock.
- i_wrst_n  input  1  asynchronous active-low reset.
- i_w_en  input  1  write request.
- i_rptr_sync  input  ADDRSIZE+1  Gray read pointer, already synchronised into i_wclk.
- i_afull_thresh  input  ADDRSIZE+1  almost-full threshold, in entries. Quasi-static.
- i_clr_ovf  input  1  clears o_wovf.
- o_waddr  output  ADDRSIZE  RAM write address, equal to wbin[ADDRSIZE-1:0].
- o_wptr  output  ADDRSIZE+1  registered Gray write pointer, sent to the read-side synchroniser.
- o_wfull_flag  output  1  FIFO full, registered.
- o_wafull_flag  output  1  almost full, registered.
- o_wlevel  output  ADDRSIZE+1  write-side fill level, range 0..2^ADDRSIZE, registered.
- o_wovf  output  1  sticky overflow flag.
- o_wack  output  1  one-cycle pulse the cycle after a write is accepted.

## Operation

- accept = i_w_en & ~o_wfull_flag. Only accepted writes advance the pointer.
- wbin_next = wbin + accept, computed modulo 2^(ADDRSIZE+1).
- wgray_next = (wbin_next >> 1) ^ wbin_next.
- wbin and o_wptr load wbin_next and wgray_next on every edge.
- Full: full_next = (wgray_next == {~i_rptr_sync[ADDRSIZE:ADDRSIZE-1], i_rptr_sync[ADDRSIZE-2:0]}). It is registered into o_wfull_flag.
- Read pointer conversion: rbin_sync = Gray-to-binary of i_rptr_sync. Bit k is the XOR of bits ADDRSIZE down to k. This is combinational.
- Level: level_next = (wbin_next - rbin_sync) modulo 2^(ADDRSIZE+1). It is registered into o_wlevel.
  - The value is pessimistic: read progress arrives late through the synchroniser, so the level never under-reports occupancy.
- Almost full: afull_next = (level_next >= i_afull_thresh), an unsigned compare. It is registered into o_wafull_flag.
  - thresh = 0 gives a constant 1 after the first edge out of reset.
  - thresh > 2^ADDRSIZE means the flag never asserts.
- Overflow: an overflow attempt is i_w_en & o_wfull_flag.
  - An attempt sets o_wovf.
  - i_clr_ovf clears it.
  - If an attempt and i_clr_ovf happen in the same cycle, set wins.
  - An attempted write never changes wbin, o_wptr, o_waddr or o_wlevel.
- Ack: o_wack is accept, registered.
- Invariants, checked after every edge:
  - o_wfull_flag == (o_wlevel == 2^ADDRSIZE).
  - o_wptr equals the Gray code of wbin.
- Reset (i_wrst_n low, asynchronous): all outputs and internal registers go to 0 immediately.
  - The flags stay deasserted while reset is held.
  - Reset in the middle of operation discards all pointer state. The read side must be reset in the same reset event.

## Timing

- Latency: o_waddr addresses the current write. The RAM writes at o_waddr on the accepting edge, and o_waddr advances on that same edge.
- o_wptr, o_wlevel, o_wfull_flag, o_wafull_flag and o_wack all reflect an accepted write on the edge that accepts it. They are valid in the following cycle.
- Full asserts on the edge that accepts the 2^ADDRSIZE-th outstanding write. With o_wfull_flag high, the very next i_w_en is blocked. Zero-slack full.
- Full deasserts on the first edge after i_rptr_sync advances, so release is 1 wclk after the synchronised pointer changes.
- If i_w_en arrives together with a read-pointer advance while full, the write is still blocked that cycle. It is accepted one cycle later.
- Wrap-around: wbin rolls 2^(ADDRSIZE+1)-1 -> 0 and the MSB toggles every 2^ADDRSIZE writes. Level arithmetic stays correct across the wrap.
- o_wovf is set on the edge after the blocked request, and cleared on the edge after i_clr_ovf.

## Test plan

All scenarios use ADDRSIZE=4 and i_rptr_sync=0 unless stated.

- **Reset:** hold i_wrst_n low mid-run after 5 writes, then release. All outputs go to 0 asynchronously and stay 0 until the first accepted write.
- **Fill to full:** 16 consecutive writes.
  - After the 16th edge: o_wfull_flag=1, o_wlevel=16, o_wptr=5'b11000, o_waddr=0.
  - A 17th request gives no pointer change and o_wovf=1. A 16th o_wack pulse is seen and no 17th.
- **Almost full:** i_afull_thresh=12. o_wafull_flag rises on the edge accepting the 12th write, with o_wlevel=12. Threshold 17 keeps the flag 0 through full.
- **Drain/release:** from full, step i_rptr_sync through Gray 1 then 3.
  - o_wfull_flag falls 1 cycle after the first step.
  - o_wlevel reads 15, then 14.
  - A held i_w_en is accepted the cycle after the flag falls.
- **Wrap-around:** stream 40 writes while keeping i_rptr_sync 4 entries behind.
  - wbin wraps 31 -> 0 and o_wptr goes 10000 -> 00000.
  - o_wlevel holds at 4 and the full flag never asserts.
- **Overflow clear:** when full, assert i_w_en and i_clr_ovf together; o_wovf stays 1. Then assert i_clr_ovf alone; o_wovf reads 0 on the next cycle.
